// File: rtl/sdrc_mp_arb.sv
// Multi-port request arbiter in front of sdrc_core: grants one port at a time and
// steers that port's request, write data and read strobes for one whole burst.
module sdrc_mp_arb #(
   parameter int NPORT    = 4,
   parameter int APP_AW   = 26,
   parameter int dw       = 32,
   parameter int bl       = 9,
   parameter int ARB_MODE = 0,
   parameter int AGE_MAX  = 8
) (
   input  logic                      sdram_clk,
   input  logic                      sdram_reset,
   input  logic [NPORT-1:0]          port_req,
   input  logic [NPORT*APP_AW-1:0]   port_req_addr,
   input  logic [NPORT*bl-1:0]       port_req_len,
   input  logic [NPORT-1:0]          port_req_wr_n,
   output logic [NPORT-1:0]          port_req_ack,
   input  logic [NPORT*dw-1:0]       port_wr_data,
   input  logic [NPORT*(dw/8)-1:0]   port_wr_en_n,
   output logic [NPORT-1:0]          port_wr_next,
   output logic [NPORT-1:0]          port_rd_valid,
   output logic [NPORT-1:0]          port_last_rd,
   output logic [dw-1:0]             port_rd_data,
   output logic                      app_req,
   output logic [APP_AW-1:0]         app_req_addr,
   output logic [bl-1:0]             app_req_len,
   output logic                      app_req_wr_n,
   input  logic                      app_req_ack,
   output logic [dw-1:0]             app_wr_data,
   output logic [dw/8-1:0]           app_wr_en_n,
   input  logic                      app_wr_next_req,
   input  logic                      app_rd_valid,
   input  logic                      app_last_rd,
   input  logic                      app_last_wr,
   input  logic [dw-1:0]             app_rd_data
);

   localparam int GW  = (NPORT > 1) ? $clog2(NPORT) : 1;
   localparam int BW  = dw / 8;
   localparam int AGW = $clog2(AGE_MAX + 1);
   localparam logic [AGW-1:0] AGE_TOP = AGW'(AGE_MAX);

   typedef enum logic [2:0] {IDLE, REQ, WR, RD, NOP} state_t;

   state_t           state;
   logic [GW-1:0]    grant;
   logic [GW-1:0]    rr_ptr;
   logic [GW-1:0]    win;
   logic [GW:0]      idx;
   logic             found;
   logic [AGW-1:0]   age [NPORT];
   logic [NPORT-1:0] grant_oh;

   // Winner selection; only consumed while IDLE.
   // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      if (ARB_MODE == 0) begin
         for (int k = 0; k < NPORT; k++) begin
            idx = {1'b0, rr_ptr} + (GW+1)'(k);
            if (idx >= (GW+1)'(NPORT))
               idx = idx - (GW+1)'(NPORT);
            if (!found && port_req[idx[GW-1:0]]) begin
               win   = idx[GW-1:0];
               found = 1'b1;
            end
         end
      end else begin
         // Starved ports outrank the static priority order.
         for (int i = 0; i < NPORT; i++) begin
            if (!found && port_req[i] && age[i] == AGE_TOP) begin
               win   = GW'(i);
               found = 1'b1;
            end
         end
         for (int i = 0; i < NPORT; i++) begin
            if (!found && port_req[i]) begin
               win   = GW'(i);
               found = 1'b1;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking '<='; the small age array is reset like any other register.
   always_ff @(posedge sdram_clk or posedge sdram_reset) begin
      if (sdram_reset) begin
         state        <= IDLE;
         grant        <= '0;
         rr_ptr       <= '0;
         app_req      <= 1'b0;
         app_req_addr <= '0;
         app_req_len  <= '0;
         app_req_wr_n <= 1'b0;
         for (int i = 0; i < NPORT; i++)
            age[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|port_req) begin
                  grant        <= win;
                  app_req_addr <= port_req_addr[int'(win)*APP_AW +: APP_AW];
                  app_req_len  <= port_req_len[int'(win)*bl +: bl];
                  app_req_wr_n <= port_req_wr_n[win];
                  rr_ptr       <= (win == GW'(NPORT-1)) ? '0 : win + 1'b1;
                  if (ARB_MODE != 0) begin
                     for (int i = 0; i < NPORT; i++) begin
                        if (GW'(i) == win || !port_req[i])
                           age[i] <= '0;
                        else if (age[i] != AGE_TOP)
                           age[i] <= age[i] + 1'b1;
                     end
                  end
                  // Zero-length requests are acknowledged locally without touching the core.
                  if (port_req_len[int'(win)*bl +: bl] == '0) begin
                     state <= NOP;
                  end else begin
                     state   <= REQ;
                     app_req <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (app_req_ack) begin
                  app_req <= 1'b0;
                  state   <= app_req_wr_n ? RD : WR;
               end
            end
            WR:      if (app_wr_next_req && app_last_wr) state <= IDLE;
            RD:      if (app_rd_valid && app_last_rd)     state <= IDLE;
            NOP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Owner-only steering of strobes and write data.
   always_comb begin
      grant_oh        = '0;
      grant_oh[grant] = 1'b1;
      port_req_ack    = '0;
      port_wr_next    = '0;
      port_rd_valid   = '0;
      port_last_rd    = '0;
      port_rd_data    = '0;
      app_wr_data     = '0;
      app_wr_en_n     = '1;
      case (state)
         REQ: port_req_ack = grant_oh & {NPORT{app_req_ack}};
         NOP: port_req_ack = grant_oh;
         WR: begin
            port_wr_next = grant_oh & {NPORT{app_wr_next_req}};
            app_wr_data  = port_wr_data[int'(grant)*dw +: dw];
            app_wr_en_n  = port_wr_en_n[int'(grant)*BW +: BW];
         end
         RD: begin
            port_rd_valid = grant_oh & {NPORT{app_rd_valid}};
            port_last_rd  = grant_oh & {NPORT{app_last_rd}};
            port_rd_data  = app_rd_data;
         end
         default: ;
      endcase
   end

endmodule
